// File: rtl/zclk_ctrl_pkg.sv
// Shared encodings for the Z80 clock scheduler: turbo modes and FSM states.
package zclk_ctrl_pkg;

    localparam logic [1:0] TURBO_3M5 = 2'b00;
    localparam logic [1:0] TURBO_7M  = 2'b01;
    localparam logic [1:0] TURBO_14M = 2'b10;

    typedef enum logic [1:0] {
        T_IDLE   = 2'b00,
        T_PEND   = 2'b01,
        T_SETTLE = 2'b10
    } turbo_state_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STOP  = 2'b01,
        S_REARM = 2'b10
    } stall_state_t;

    // Both 2'b10 and 2'b11 select 14 MHz, so only the upper bit matters.
    function automatic logic is_14m(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/zclk_stall.sv
// Contended-access stall FSM: freezes the Z80 clock in 14 MHz mode, bounded
// to STALL_MAX cycles, then waits for the request to drop before re-arming.
module zclk_stall
    import zclk_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 15
) (
    input  logic fclk,
    input  logic rst,
    input  logic stall_req,
    input  logic turbo_14m,
    output logic clk_stop,
    output logic stall_tmo
);

    // Counter holds full cycles already spent in STOP, so the last one is STALL_MAX-1.
    localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

    stall_state_t state_r;
    logic [7:0]   cnt_r;
    logic         clk_stop_r;
    logic         stall_tmo_r;

    // Stall state machine with registered clk_stop / stall_tmo.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r     <= S_RUN;
            cnt_r       <= 8'd0;
            clk_stop_r  <= 1'b0;
            stall_tmo_r <= 1'b0;
        end else begin
            stall_tmo_r <= 1'b0;
            case (state_r)
                S_RUN: begin
                    if (stall_req && turbo_14m) begin
                        state_r    <= S_STOP;
                        cnt_r      <= 8'd0;
                        clk_stop_r <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (!stall_req || !turbo_14m) begin
                        state_r    <= S_RUN;
                        clk_stop_r <= 1'b0;
                    end else if (cnt_r == STALL_LAST) begin
                        state_r     <= S_REARM;
                        clk_stop_r  <= 1'b0;
                        stall_tmo_r <= 1'b1;
                    end else if (cnt_r != 8'hFF) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                S_REARM: begin
                    if (!stall_req) begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r    <= S_RUN;
                    clk_stop_r <= 1'b0;
                end
            endcase
        end
    end

    assign clk_stop  = clk_stop_r;
    assign stall_tmo = stall_tmo_r;

endmodule

// File: rtl/zclk_ctrl.sv
// Turbo-mode change scheduler for the Z80 clock generator: applies requested
// modes only on half-pre_cend boundaries, then settles; wraps the stall FSM.
module zclk_ctrl
    import zclk_ctrl_pkg::*;
#(
    parameter int SETTLE_PERIODS = 2,
    parameter int STALL_MAX      = 15
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       pre_cend,
    input  logic [1:0] turbo_req,
    input  logic       turbo_wr,
    input  logic       stall_req,
    output logic [1:0] turbo,
    output logic       clk_stop,
    output logic       chg_done,
    output logic       busy,
    output logic       stall_tmo
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_PERIODS);

    turbo_state_t state_r;
    logic         phase_r;
    logic [1:0]   turbo_r;
    logic [1:0]   pend_val_r;
    logic         held_r;
    logic [7:0]   settle_cnt_r;
    logic         chg_done_r;
    logic         busy_r;

    logic         boundary_s;
    logic [1:0]   pend_nxt_s;
    logic         held_nxt_s;
    logic         settle_exit_s;
    logic         take_held_s;
    logic         clk_stop_s;

    // Boundary decode and the held-write view used at the end of a settle window.
    always_comb begin
        boundary_s = pre_cend & phase_r;
        if (turbo_wr) begin
            pend_nxt_s = turbo_req;
            held_nxt_s = 1'b1;
        end else begin
            pend_nxt_s = pend_val_r;
            held_nxt_s = held_r;
        end
        settle_exit_s = (settle_cnt_r == 8'd0) || (boundary_s && (settle_cnt_r == 8'd1));
        take_held_s   = held_nxt_s && (pend_nxt_s != turbo_r);
    end

    // Phase tracker: toggles on every pre_cend.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else if (pre_cend) begin
            phase_r <= ~phase_r;
        end
    end

    // Turbo FSM with registered turbo, chg_done and busy.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r      <= T_IDLE;
            turbo_r      <= TURBO_3M5;
            pend_val_r   <= TURBO_3M5;
            held_r       <= 1'b0;
            settle_cnt_r <= 8'd0;
            chg_done_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            chg_done_r <= 1'b0;
            case (state_r)
                T_IDLE: begin
                    if (turbo_wr && (turbo_req != turbo_r)) begin
                        pend_val_r <= turbo_req;
                        held_r     <= 1'b0;
                        state_r    <= T_PEND;
                        busy_r     <= 1'b1;
                    end
                end
                T_PEND: begin
                    // A boundary under clk_stop is skipped; a write with the boundary becomes held.
                    if (boundary_s && !clk_stop_s) begin
                        turbo_r      <= pend_val_r;
                        chg_done_r   <= 1'b1;
                        settle_cnt_r <= SETTLE_LOAD;
                        pend_val_r   <= pend_nxt_s;
                        held_r       <= turbo_wr;
                        state_r      <= T_SETTLE;
                    end else if (turbo_wr) begin
                        if (turbo_req == turbo_r) begin
                            held_r  <= 1'b0;
                            state_r <= T_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            pend_val_r <= turbo_req;
                            held_r     <= 1'b1;
                        end
                    end
                end
                T_SETTLE: begin
                    pend_val_r <= pend_nxt_s;
                    if (boundary_s && (settle_cnt_r != 8'd0)) begin
                        settle_cnt_r <= settle_cnt_r - 8'd1;
                    end
                    if (settle_exit_s) begin
                        held_r <= 1'b0;
                        if (take_held_s) begin
                            state_r <= T_PEND;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= T_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        held_r <= held_nxt_s;
                    end
                end
                default: begin
                    state_r <= T_IDLE;
                    held_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    zclk_stall #(
        .STALL_MAX (STALL_MAX)
    ) u_stall (
        .fclk      (fclk),
        .rst       (rst),
        .stall_req (stall_req),
        .turbo_14m (is_14m(turbo_r)),
        .clk_stop  (clk_stop_s),
        .stall_tmo (stall_tmo)
    );

    assign turbo    = turbo_r;
    assign clk_stop = clk_stop_s;
    assign chg_done = chg_done_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_zclk_ctrl.sv
// Directed plus randomized bench for zclk_ctrl, checked cycle by cycle
// against a behavioural model of the mode-change and stall rules.
module tb_zclk_ctrl;

    localparam int SETTLE = 2;
    localparam int SMAX   = 15;

    logic       fclk = 1'b0;
    logic       rst  = 1'b1;
    logic       pre_cend = 1'b0;
    logic [1:0] turbo_req = 2'b00;
    logic       turbo_wr = 1'b0;
    logic       stall_req = 1'b0;
    logic [1:0] turbo;
    logic       clk_stop, chg_done, busy, stall_tmo;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int m_turbo, m_pend, m_settle, m_elapsed;
    bit m_phase, m_has_pend, m_stop, m_lock, m_chg, m_tmo;

    zclk_ctrl #(.SETTLE_PERIODS(SETTLE), .STALL_MAX(SMAX)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .pre_cend  (pre_cend),
        .turbo_req (turbo_req),
        .turbo_wr  (turbo_wr),
        .stall_req (stall_req),
        .turbo     (turbo),
        .clk_stop  (clk_stop),
        .chg_done  (chg_done),
        .busy      (busy),
        .stall_tmo (stall_tmo)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_turbo = 0; m_pend = 0; m_settle = 0; m_elapsed = 0;
        m_phase = 0; m_has_pend = 0; m_stop = 0; m_lock = 0; m_chg = 0; m_tmo = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_turbo"}, 8'(turbo), 8'h00);
        check({tag, "_clk_stop"}, 8'(clk_stop), 8'h00);
        check({tag, "_chg_done"}, 8'(chg_done), 8'h00);
        check({tag, "_busy"}, 8'(busy), 8'h00);
        check({tag, "_stall_tmo"}, 8'(stall_tmo), 8'h00);
    endtask

    // One clock: advance the model from the current inputs, then compare all outputs.
    task automatic tick();
        bit bnd, n_stop, n_lock, n_tmo, n_hp, n_chg;
        int n_el, n_turbo, n_pend, n_settle;
        bnd = pre_cend && m_phase;

        n_stop = m_stop; n_lock = m_lock; n_el = m_elapsed; n_tmo = 0;
        if (m_stop) begin
            n_el = m_elapsed + 1;
            if (!stall_req || m_turbo < 2) n_stop = 0;
            else if (n_el == SMAX) begin n_stop = 0; n_lock = 1; n_tmo = 1; end
        end else if (m_lock) begin
            if (!stall_req) n_lock = 0;
        end else if (stall_req && m_turbo >= 2) begin
            n_stop = 1; n_el = 0;
        end

        n_turbo = m_turbo; n_pend = m_pend; n_settle = m_settle; n_hp = m_has_pend; n_chg = 0;
        if (m_settle > 0) begin
            if (turbo_wr) begin n_hp = 1; n_pend = int'(turbo_req); end
            if (bnd) n_settle = m_settle - 1;
            if (n_settle == 0 && n_hp && n_pend == m_turbo) n_hp = 0;
        end else if (m_has_pend) begin
            if (bnd && !m_stop) begin
                n_turbo = m_pend; n_chg = 1; n_settle = SETTLE; n_hp = turbo_wr;
                if (turbo_wr) n_pend = int'(turbo_req);
            end else if (turbo_wr) begin
                if (int'(turbo_req) == m_turbo) n_hp = 0;
                else n_pend = int'(turbo_req);
            end
        end else if (turbo_wr && int'(turbo_req) != m_turbo) begin
            n_hp = 1; n_pend = int'(turbo_req);
        end

        @(posedge fclk);
        #1;
        m_stop = n_stop; m_lock = n_lock; m_elapsed = n_el; m_tmo = n_tmo;
        m_turbo = n_turbo; m_pend = n_pend; m_settle = n_settle; m_has_pend = n_hp; m_chg = n_chg;
        m_phase = m_phase ^ pre_cend;

        check("turbo", 8'(turbo), 8'(m_turbo));
        check("clk_stop", 8'(clk_stop), 8'(m_stop));
        check("chg_done", 8'(chg_done), 8'(m_chg));
        check("busy", 8'(busy), 8'(m_has_pend || m_settle > 0));
        check("stall_tmo", 8'(stall_tmo), 8'(m_tmo));
    endtask

    task automatic pulse();
        pre_cend = 1'b1; tick(); pre_cend = 1'b0; tick();
    endtask

    task automatic wr(input logic [1:0] req);
        turbo_wr = 1'b1; turbo_req = req; tick(); turbo_wr = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_vals(tag);
        model_reset();
        pre_cend = 1'b0; turbo_wr = 1'b0; stall_req = 1'b0;
        @(negedge fclk) rst = 1'b0;
    endtask

    initial begin
        int hi, tmo_cnt;
        model_reset();
        #12 check_reset_vals("reset");
        @(negedge fclk) rst = 1'b0;

        // basic change 3.5 -> 7 MHz
        wr(2'b01);
        tick();
        pulse();
        pre_cend = 1'b1; tick(); pre_cend = 1'b0;
        check("basic_turbo", 8'(turbo), 8'h01);
        check("basic_chg", 8'(chg_done), 8'h01);
        tick();
        pulse(); pulse(); pulse();
        check("basic_busy_settle", 8'(busy), 8'h01);
        pulse();
        check("basic_busy_end", 8'(busy), 8'h00);

        // last write wins inside one PEND window
        wr(2'b00); tick(); wr(2'b10);
        pulse(); pulse();
        check("lww_turbo", 8'(turbo), 8'h02);

        // write during SETTLE, applied after settle expires
        wr(2'b00);
        repeat (4) pulse();
        check("settle_turbo_held", 8'(turbo), 8'h02);
        repeat (2) pulse();
        check("settle_turbo_applied", 8'(turbo), 8'h00);
        repeat (4) pulse();

        // normal stall at 14 MHz, then at 7 MHz
        wr(2'b10);
        repeat (6) pulse();
        hi = 0;
        stall_req = 1'b1;
        repeat (5) begin tick(); if (clk_stop) hi++; end
        stall_req = 1'b0;
        repeat (3) begin tick(); if (clk_stop) hi++; end
        check("stall14_len", 8'(hi), 8'd5);
        wr(2'b01);
        repeat (6) pulse();
        hi = 0;
        stall_req = 1'b1;
        repeat (5) begin tick(); if (clk_stop) hi++; end
        stall_req = 1'b0;
        repeat (3) begin tick(); if (clk_stop) hi++; end
        check("stall7_len", 8'(hi), 8'd0);

        // stall timeout
        wr(2'b10);
        repeat (6) pulse();
        hi = 0; tmo_cnt = 0;
        stall_req = 1'b1;
        repeat (40) begin tick(); if (clk_stop) hi++; if (stall_tmo) tmo_cnt++; end
        stall_req = 1'b0;
        repeat (3) tick();
        check("tmo_len", 8'(hi), 8'(SMAX));
        check("tmo_pulses", 8'(tmo_cnt), 8'd1);

        // boundary during STOP is skipped; then reset mid-stall with a change pending
        stall_req = 1'b1;
        tick();
        wr(2'b01);
        pulse(); pulse();
        check("blocked_turbo", 8'(turbo), 8'h02);
        check("blocked_busy", 8'(busy), 8'h01);
        check("blocked_stop", 8'(clk_stop), 8'h01);
        async_reset("rst_stop");
        wr(2'b01); tick();
        async_reset("rst_pend");

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            pre_cend  = !pre_cend && ($urandom_range(0, 2) == 0);
            turbo_wr  = ($urandom_range(0, 11) == 0);
            turbo_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) stall_req = ~stall_req;
            tick();
            if (i % 1000 == 999) async_reset("rst_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zclk_ctrl.md
# zclk_ctrl

Scheduler in front of the Z80 clock generator. It accepts turbo-mode change requests from the config register file and applies them only on the generator's half-`pre_cend` phase boundary, then holds a settle window. In 14 MHz mode it also stops the Z80 clock while the DRAM arbiter reports a pending contended access, with a bounded stall length.

## Interface
- `SETTLE_PERIODS`, default 2: number of phase boundaries after an applied change during which further changes are held pending.
- `STALL_MAX`, default 15: maximum consecutive `fclk` cycles of `clk_stop`; range 1..255.
- `fclk  in  1`: system clock (28 MHz).
- `rst  in  1`: asynchronous, active-high reset.
- `pre_cend  in  1`: one-cycle sync pulse from the arbiter.
- `turbo_req  in  2`: requested mode; 00 = 3.5 MHz, 01 = 7 MHz, 1x = 14 MHz.
- `turbo_wr  in  1`: one-cycle strobe; captures `turbo_req`.
- `stall_req  in  1`: level from the arbiter, meaning a Z80 access is contended.
- `turbo  out  2`: applied mode, fed to the clock generator.
- `clk_stop  out  1`: freeze the Z80 clock (generator holds `zclk_out`).
- `chg_done  out  1`: one-cycle pulse when a new `turbo` value is applied.
- `busy  out  1`: high while a change is pending or the block is settling.
- `stall_tmo  out  1`: one-cycle pulse when a stall is cut by `STALL_MAX`.

## Operation
- **Phase tracker**
  - 1-bit `phase` toggles on every `pre_cend`.
  - A boundary is `pre_cend && phase==1`, which matches the generator's half-`pre_cend`.
  - `phase` resets to 0.
- **Turbo FSM states:** IDLE, PEND, SETTLE.
  - IDLE: on `turbo_wr` with `turbo_req != turbo`, latch the request into `pend_val` and go to PEND. If the request equals `turbo`, it is ignored.
  - PEND: at the first boundary where `clk_stop==0`:
    - register `turbo <= pend_val`
    - pulse `chg_done`
    - load the settle counter with `SETTLE_PERIODS`
    - go to SETTLE.
    A boundary that occurs while `clk_stop==1` is skipped.
  - SETTLE: decrement on each boundary. At 0, go to PEND if a write is held, otherwise go to IDLE.
  - `turbo_wr` in PEND or SETTLE overwrites `pend_val` (last write wins) and sets the held flag. In PEND, a write equal to the current `turbo` cancels the change and returns to IDLE.
  - `busy` = state != IDLE.
- **Stall FSM states:** RUN, STOP, REARM.
  - RUN → STOP when `stall_req==1` and `turbo[1]==1`.
  - STOP → RUN when `stall_req` drops.
  - STOP → REARM when the stall counter reaches `STALL_MAX`; pulse `stall_tmo`.
  - REARM → RUN when `stall_req==0`.
  - `clk_stop` is high only in STOP.
  - The stall counter is 8 bits, cleared on STOP entry, and saturates; it does not wrap.
  - If `turbo` leaves 14 MHz during STOP, the FSM exits to RUN the next cycle. This cannot happen under normal operation because changes are blocked during a stall, but the exit is required anyway.
- **Simultaneous events**
  - A boundary and `stall_req` rising in the same cycle: the change is applied, and the stall decision is evaluated against the new `turbo` on the following cycle.
  - `turbo_wr` arriving in the same cycle as a boundary in IDLE: the write is latched, and the change waits for the next boundary.

## Timing
- Reset values:
  - `turbo` = 00
  - `clk_stop` = 0
  - `chg_done` = 0
  - `busy` = 0
  - `stall_tmo` = 0
  - `phase` = 0
  - both FSMs at IDLE/RUN.
- Reset asserted mid-change drops the pending request. Reset asserted mid-stall releases `clk_stop` immediately (asynchronous).
- `turbo` and `chg_done` are registered: they change 1 cycle after the boundary cycle.
- `clk_stop` rises 1 cycle after `stall_req` is sampled and falls 1 cycle after `stall_req` is sampled low.
- Maximum `clk_stop` high time is exactly `STALL_MAX` cycles.
- Minimum spacing between two `chg_done` pulses is (`SETTLE_PERIODS`+1) boundaries.
- All outputs are registered on the `fclk` posedge. No combinational input-to-output path exists.

## Structure
- The shared include gets:
  - turbo mode encodings (`TURBO_3M5`, `TURBO_7M`, `TURBO_14M`)
  - FSM state encodings for both FSMs.
- One sub-module, `zclk_stall`: the RUN/STOP/REARM FSM with its counter. The turbo FSM and phase tracker stay in the top module.

## Test plan
- **Basic change:** reset, then `turbo_wr` with 01 → `turbo`=01 one cycle after the second `pre_cend`; `chg_done` is a single pulse; `busy` stays high through 2 further boundaries.
- **Last-write-wins:** writes of 01 then 1x inside one PEND window → only 1x is applied; exactly one `chg_done`.
- **Write during SETTLE:** write 00 during SETTLE → applied at the first boundary after settle expires; `busy` stays continuously high.
- **Normal stall:** `turbo`=1x, `stall_req` high for 5 cycles → `clk_stop` high for 5 cycles, delayed by 1; no `stall_tmo`. Same stimulus at `turbo`=01 → `clk_stop` stays 0.
- **Stall timeout:** `stall_req` held 40 cycles with `STALL_MAX`=15 → `clk_stop` high exactly 15 cycles, one `stall_tmo` pulse, no re-stall until `stall_req` drops.
- **Reset and blocked boundary:**
  - Assert `rst` during PEND and during STOP → all outputs return to reset values asynchronously.
  - A boundary occurring during STOP does not apply the pending change.
